// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use stall detection.
// A stall or a flush turns the instruction entering EX into a bubble.
// While stallOut is high, IF and ID are expected to hold their contents.
module id_ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               idValid,
  input  logic [REG_AW-1:0]  idRs,
  input  logic [REG_AW-1:0]  idRt,
  input  logic [REG_AW-1:0]  idRd,
  input  logic [DATA_W-1:0]  idRsData,
  input  logic [DATA_W-1:0]  idRtData,
  input  logic [DATA_W-1:0]  idImm,
  input  logic               idAluSrc,
  input  logic [ALUOP_W-1:0] idAluOp,
  input  logic               idRegWrite,
  input  logic               idMemRead,
  input  logic               idMemWrite,
  input  logic               flush,
  input  logic               exMemRegWrite,
  input  logic [REG_AW-1:0]  exMemRd,
  input  logic [DATA_W-1:0]  exMemResult,
  input  logic               memWbRegWrite,
  input  logic [REG_AW-1:0]  memWbRd,
  input  logic [DATA_W-1:0]  memWbResult,
  output logic               stallOut,
  output logic [DATA_W-1:0]  aluInA,
  output logic [DATA_W-1:0]  aluInB,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               exValid,
  output logic               exRegWrite,
  output logic               exMemRead,
  output logic               exMemWrite,
  output logic [REG_AW-1:0]  exRd,
  output logic [DATA_W-1:0]  exStoreData
);

  logic               valid_q,     valid_d;
  logic [REG_AW-1:0]  rs_q,        rs_d;
  logic [REG_AW-1:0]  rt_q,        rt_d;
  logic [REG_AW-1:0]  rd_q,        rd_d;
  logic [DATA_W-1:0]  rs_data_q,   rs_data_d;
  logic [DATA_W-1:0]  rt_data_q,   rt_data_d;
  logic [DATA_W-1:0]  imm_q,       imm_d;
  logic               alu_src_q,   alu_src_d;
  logic [ALUOP_W-1:0] alu_op_q,    alu_op_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q,  mem_read_d;
  logic               mem_write_q, mem_write_d;

  logic               load_use;
  logic [DATA_W-1:0]  rt_fwd;

  // Newest producer wins; $0 is hard-wired zero and must never pick up a forwarded value.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] reg_val,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] val;
    val = reg_val;
    if (em_we && (em_rd != '0) && (em_rd == idx)) begin
      val = em_res;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
      val = mw_res;
    end
    return val;
  endfunction

  // Load-use hazard: a load in EX whose destination feeds the instruction sitting in ID.
  always_comb begin
    load_use = idValid && valid_q && mem_read_q && (rd_q != '0) &&
               ((rd_q == idRs) || (rd_q == idRt));
  end

  // Next EX contents: capture ID, or a bubble on flush/stall (flush and stall share the bubble).
  always_comb begin
    valid_d     = idValid;
    rs_d        = idRs;
    rt_d        = idRt;
    rd_d        = idRd;
    rs_data_d   = idRsData;
    rt_data_d   = idRtData;
    imm_d       = idImm;
    alu_src_d   = idAluSrc;
    alu_op_d    = idAluOp;
    reg_write_d = idRegWrite && idValid;
    mem_read_d  = idMemRead  && idValid;
    mem_write_d = idMemWrite && idValid;
    if (flush || load_use) begin
      valid_d     = 1'b0;
      rs_d        = '0;
      rt_d        = '0;
      rd_d        = '0;
      rs_data_d   = '0;
      rt_data_d   = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      alu_op_d    = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  // ID/EX register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_op_q    <= alu_op_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Zero-cycle operand forwarding from the EX registers.
  always_comb begin
    rt_fwd      = fwd(rt_q, rt_data_q, exMemRegWrite, exMemRd, exMemResult,
                      memWbRegWrite, memWbRd, memWbResult);
    aluInA      = fwd(rs_q, rs_data_q, exMemRegWrite, exMemRd, exMemResult,
                      memWbRegWrite, memWbRd, memWbResult);
    aluInB      = alu_src_q ? imm_q : rt_fwd;
    exStoreData = rt_fwd;
  end

  assign stallOut   = load_use;
  assign aluOp      = alu_op_q;
  assign exValid    = valid_q;
  assign exRegWrite = reg_write_q;
  assign exMemRead  = mem_read_q;
  assign exMemWrite = mem_write_q;
  assign exRd       = rd_q;

endmodule
